stream_demux_1x2: RTL
=====================

Name: stream_demux_1x2

Overview:
Registered, flow-controlled 1-to-2 demultiplexer that steers a valid/ready data stream to channel A or channel B by a per-beat select bit. Each output channel has its own small FIFO, so a stalled consumer on one channel does not block traffic to the other until its own FIFO fills. This block is the sequential successor to the plain combinational demux and sits between a single producer and two independent consumers.

Parameters:
DATA_W, 8, width of the data payload
DEPTH, 2, entries per output FIFO; power of two, at least 2
COUNT_W, 16, width of the per-channel delivered-beat counters

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a beat on in_data/in_sel
in_ready  output  1  block accepts the beat this cycle
in_sel  input  1  steering: 0 sends the beat to channel A, 1 sends it to channel B
in_data  input  DATA_W  payload
a_valid  output  1  channel A FIFO non-empty
a_ready  input  1  channel A consumer accepts
a_data  output  DATA_W  head of channel A FIFO
b_valid  output  1  channel B FIFO non-empty
b_ready  input  1  channel B consumer accepts
b_data  output  DATA_W  head of channel B FIFO
a_count  output  COUNT_W  beats delivered on A (a_valid and a_ready)
b_count  output  COUNT_W  beats delivered on B
a_full  output  1  channel A FIFO holds DEPTH entries
b_full  output  1  channel B FIFO holds DEPTH entries

Behaviour:
- Reset (rst_n low, asynchronous):
  - All FIFO pointers and occupancy counts go to 0.
  - a_valid = b_valid = 0; a_full = b_full = 0; a_count = b_count = 0.
  - a_data and b_data read 0 while empty.
  - Reset asserted mid-transfer discards all buffered beats.
- Input acceptance:
  - in_ready = in_sel ? !b_full : !a_full. This is purely combinational from in_sel and FIFO state, with no path from a_ready or b_ready.
  - A transfer occurs when in_valid && in_ready; the beat is pushed into the selected FIFO only. The unselected FIFO is untouched.
- Latency: a beat accepted at edge N is visible on x_valid/x_data after edge N. That is 1 cycle minimum, and only when that FIFO was empty.
- Output: x_valid = occupancy != 0. x_data = head entry, a registered-array read with no bubble. A pop occurs when x_valid && x_ready.
- Simultaneous push and pop on the same FIFO:
  - If not full, occupancy is unchanged and both pointers advance.
  - When full, in_ready is already 0, so no push occurs. The pop proceeds and in_ready rises on the next cycle. No pass-through path.
- Pointers wrap modulo DEPTH. Occupancy is held in log2(DEPTH)+1 bits, so the full and empty states are unambiguous.
- Protocol rules:
  - Once x_valid is high, x_data stays stable until the pop.
  - The producer may change in_sel or in_data freely while in_valid is low. While in_valid is high and in_ready is low, behaviour is defined per cycle using the current in_sel, so re-steering is legal.
- Counters:
  - a_count increments by 1 on each A pop; b_count likewise on each B pop.
  - Counters wrap from 2^COUNT_W-1 to 0 and do not saturate.
- No beat is ever dropped or duplicated, and order within a channel is preserved.

Decomposition:
- Shared package stream_pkg:
  - constant DEMUX_SEL_A = 1'b0 and DEMUX_SEL_B = 1'b1;
  - a function for log2 sizing used for the pointer widths.
- One natural sub-module: sync_fifo.
  - Parameters: DATA_W, DEPTH.
  - Ports: clk, rst_n, push, push_data, pop, head_data, empty, full.
  - It is instantiated twice, once for A and once for B.
- The top level holds the steering logic, in_ready generation and the two counters.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with 2 beats buffered in A -> a_valid=0, a_count=0 and in_ready=1 immediately, with no clock needed.
- Basic steering: send 0x11 (sel=0) then 0x22 (sel=1) with both ready=1 -> a_data=0x11 one cycle after acceptance and b_data=0x22 one cycle after its own acceptance; a_count=1 and b_count=1.
- Backpressure isolation: hold a_ready=0 and send 3 beats to A (DEPTH=2) -> a_full=1 and in_ready=0 for the 3rd beat. A following sel=1 beat 0x33 is still accepted and delivered on B.
- Full drain with simultaneous events: with A full, pulse a_ready=1 for one cycle -> one pop occurs. The pending A beat is accepted the next cycle, order 0xA0, 0xA1, 0xA2 is preserved, and there is no loss.
- Streaming throughput: with a_ready=1 continuously, send 100 back-to-back beats at sel=0 -> one acceptance per cycle and a_count=100.
- Counter wrap: with COUNT_W=4, deliver 17 beats on B -> b_count=1.

Source files
------------

// File: rtl/stream_demux_1x2_pkg.sv
// stream_pkg: shared steering constants and sizing helper for the stream demux.
package stream_pkg;

    localparam logic DEMUX_SEL_A = 1'b0;
    localparam logic DEMUX_SEL_B = 1'b1;

    function automatic int log2_ceil(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/stream_demux_1x2_sync_fifo.sv
// sync_fifo: power-of-two FIFO with registered storage and a zeroed head when empty.
module sync_fifo
    import stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = log2_ceil(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push, do_pop;

    // One extra occupancy bit keeps full and empty distinct without pointer tricks.
    assign empty     = count == '0;
    assign full      = count == FULL_CNT;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push != do_pop) count <= do_push ? count + CNT_W'(1) : count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/stream_demux_1x2.sv
// stream_demux_1x2: steers a valid/ready stream into per-channel FIFOs by in_sel,
// with per-channel delivered-beat counters.
module stream_demux_1x2
    import stream_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sel,
    input  logic [DATA_W-1:0]  in_data,
    output logic               a_valid,
    input  logic               a_ready,
    output logic [DATA_W-1:0]  a_data,
    output logic               b_valid,
    input  logic               b_ready,
    output logic [DATA_W-1:0]  b_data,
    output logic [COUNT_W-1:0] a_count,
    output logic [COUNT_W-1:0] b_count,
    output logic               a_full,
    output logic               b_full
);

    logic a_empty, b_empty, push_a, push_b, pop_a, pop_b;

    // Readiness depends only on the selected FIFO, never on consumer ready.
    assign in_ready = (in_sel == DEMUX_SEL_B) ? !b_full : !a_full;
    assign push_a   = in_valid && in_ready && (in_sel == DEMUX_SEL_A);
    assign push_b   = in_valid && in_ready && (in_sel == DEMUX_SEL_B);
    assign a_valid  = !a_empty;
    assign b_valid  = !b_empty;
    assign pop_a    = a_valid && a_ready;
    assign pop_b    = b_valid && b_ready;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .pop       (pop_a),
        .head_data (a_data),
        .empty     (a_empty),
        .full      (a_full)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .pop       (pop_b),
        .head_data (b_data),
        .empty     (b_empty),
        .full      (b_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (pop_a) a_count <= a_count + COUNT_W'(1);
            if (pop_b) b_count <= b_count + COUNT_W'(1);
        end
    end

endmodule
